mux2: RTL and testbench

- Parameterised 2:1 data multiplexer; the combinational output z selects d0 (sel=0) or d1 (sel=1) with zero latency.
- Also provides a registered copy of the selected data and a one-cycle select-change flag for downstream synchronous logic.
- Used as a leaf datapath primitive wherever a clocked consumer needs a glitch-free, registered copy of the mux output.

---
 rtl/mux2_pkg.sv | 27 ++
 rtl/mux2_core.sv | 23 ++
 rtl/mux2.sv | 94 +++++++++
 tb/tb_mux2.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux2_pkg.sv
// ----------------------------------------------------------------------------
// mux2_pkg
// Shared definitions for the mux2 leaf primitive.
//   MUX2_DEF_WIDTH : default data width
//   MUX2_DEF_CNT_W : default width of the optional select-change counter
//   MUX2_MAX_W     : widest data path the select helper handles
//   mux2_sel()     : 2:1 select used by both the combinational and the
//                    registered path, so the two can never disagree.
// ----------------------------------------------------------------------------
package mux2_pkg;

    localparam int MUX2_DEF_WIDTH = 1;
    localparam int MUX2_DEF_CNT_W = 8;
    localparam int MUX2_MAX_W     = 64;

    // Callers widen their operands to MUX2_MAX_W and cast the result back.
    // The ternary form is kept so an X on sel merges d0/d1 in simulation
    // instead of silently picking one side.
    function automatic logic [MUX2_MAX_W-1:0] mux2_sel(
        input logic [MUX2_MAX_W-1:0] d0,
        input logic [MUX2_MAX_W-1:0] d1,
        input logic                  sel
    );
        return sel ? d1 : d0;
    endfunction

endpackage

// File: rtl/mux2_core.sv
// ----------------------------------------------------------------------------
// mux2_core
// Pure combinational WIDTH-bit 2:1 select.
// Ports:
//   d0  in  [WIDTH-1:0]  data selected when sel=0
//   d1  in  [WIDTH-1:0]  data selected when sel=1
//   sel in  1            select
//   z   out [WIDTH-1:0]  selected data, no clock involvement
// ----------------------------------------------------------------------------
module mux2_core
    import mux2_pkg::*;
#(
    parameter int WIDTH = MUX2_DEF_WIDTH
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    output logic [WIDTH-1:0] z
);

    assign z = WIDTH'(mux2_sel(MUX2_MAX_W'(d0), MUX2_MAX_W'(d1), sel));

endmodule

// File: rtl/mux2.sv
// ----------------------------------------------------------------------------
// mux2
// Parameterised 2:1 data multiplexer with a registered copy of the selected
// data and a one-cycle select-change flag.
// Optional feature macro: MUX2_SELCNT_EN (adds the saturating sel_cnt port).
// Ports:
//   clk     in  1            rising-edge clock
//   rst     in  1            synchronous active-high reset (does not affect z)
//   d0      in  [WIDTH-1:0]  data selected when sel=0
//   d1      in  [WIDTH-1:0]  data selected when sel=1
//   sel     in  1            select
//   z       out [WIDTH-1:0]  combinational mux output
//   z_q     out [WIDTH-1:0]  mux output registered one cycle later
//   sel_chg out 1            pulse when sel differs from its previous-edge value
//   sel_cnt out [CNT_W-1:0]  saturating select-change count (MUX2_SELCNT_EN only)
// ----------------------------------------------------------------------------
module mux2
    import mux2_pkg::*;
#(
    parameter int WIDTH = MUX2_DEF_WIDTH,
    parameter int CNT_W = MUX2_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] z_q,
    output logic             sel_chg
`ifdef MUX2_SELCNT_EN
    ,
    output logic [CNT_W-1:0] sel_cnt
`endif
);

    // Reject illegal parameterisations at elaboration time.
    if ((WIDTH < 1) || (WIDTH > MUX2_MAX_W) || (CNT_W < 1) || (CNT_W > 32)) begin : g_bad_params
        $error("mux2: WIDTH must be 1..64 and CNT_W must be 1..32");
    end

    logic [WIDTH-1:0] z_d_s;
    logic             sel_diff_s;
    logic [WIDTH-1:0] z_q_r;
    logic             sel_q_r;
    logic             sel_chg_r;

    mux2_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .d0  (d0),
        .d1  (d1),
        .sel (sel),
        .z   (z)
    );

    // The registered path uses the same select helper as the core.
    assign z_d_s      = WIDTH'(mux2_sel(MUX2_MAX_W'(d0), MUX2_MAX_W'(d1), sel));
    assign sel_diff_s = (sel != sel_q_r);

    // Registered mux output, select history and select-change pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_q_r     <= {WIDTH{1'b0}};
            sel_q_r   <= 1'b0;
            sel_chg_r <= 1'b0;
        end else begin
            z_q_r     <= z_d_s;
            sel_q_r   <= sel;
            sel_chg_r <= sel_diff_s;
        end
    end

    assign z_q     = z_q_r;
    assign sel_chg = sel_chg_r;

`ifdef MUX2_SELCNT_EN
    logic [CNT_W-1:0] sel_cnt_r;

    // Saturating count of select changes; reset wins over a same-edge change.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_cnt_r <= {CNT_W{1'b0}};
        end else if (sel_diff_s && (sel_cnt_r != {CNT_W{1'b1}})) begin
            sel_cnt_r <= sel_cnt_r + CNT_W'(1'b1);
        end else begin
            sel_cnt_r <= sel_cnt_r;
        end
    end

    assign sel_cnt = sel_cnt_r;
`endif

endmodule

// File: tb/tb_mux2.sv
// ----------------------------------------------------------------------------
// tb_mux2
// Self-checking bench for mux2 (WIDTH=8, CNT_W=2). Build with MUX2_SELCNT_EN
// defined to also cover the select-change counter.
// ----------------------------------------------------------------------------
module tb_mux2;

    localparam int W     = 8;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic         clk;
    logic         rst;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         sel;
    logic [W-1:0] z;
    logic [W-1:0] z_q;
    logic         sel_chg;
`ifdef MUX2_SELCNT_EN
    logic [CW-1:0] sel_cnt;
`endif

    int vecs;
    int errs;

    // Reference model state: what the outputs must be after the latest edge.
    logic [W-1:0] m_zq;
    logic         m_chg;
    int           m_cnt;
    logic         m_prev_sel;

    mux2 #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .d0      (d0),
        .d1      (d1),
        .sel     (sel),
        .z       (z),
        .z_q     (z_q),
        .sel_chg (sel_chg)
`ifdef MUX2_SELCNT_EN
        ,
        .sel_cnt (sel_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and update the model from the rules; returns #1 after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_zq       = '0;
            m_chg      = 1'b0;
            m_cnt      = 0;
            m_prev_sel = 1'b0;
        end else begin
            m_zq  = sel ? d1 : d0;
            m_chg = (sel != m_prev_sel);
            if (m_chg) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
            m_prev_sel = sel;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; d0 = 8'h01; d1 = 8'h00; sel = 1'b0;
        #1;
        vecs++;
        if (z !== 8'h01) begin errs++; $display("FAIL reset_z_pre got %h want 01", z); end
        for (int i = 0; i < 2; i++) begin
            tick();
            vecs++;
            if (z_q !== 8'h00) begin errs++; $display("FAIL reset_zq got %h want 00", z_q); end
            vecs++;
            if (sel_chg !== 1'b0) begin errs++; $display("FAIL reset_chg got %b want 0", sel_chg); end
            vecs++;
            if (z !== 8'h01) begin errs++; $display("FAIL reset_z got %h want 01", z); end
`ifdef MUX2_SELCNT_EN
            vecs++;
            if (sel_cnt !== 2'd0) begin errs++; $display("FAIL reset_cnt got %0d want 0", sel_cnt); end
`endif
        end
        rst = 1'b0;
        tick();
        vecs++;
        if (z_q !== 8'h01) begin errs++; $display("FAIL reset_release_zq got %h want 01", z_q); end
        vecs++;
        if (sel_chg !== 1'b0) begin errs++; $display("FAIL reset_release_chg got %b want 0", sel_chg); end
    endtask

    // Held in reset so the sweep also shows z ignoring rst.
    task automatic test_comb_sweep();
        logic [7:0] ztab;
        ztab = 8'b1100_1010;
        rst  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d0  = {7'b0, i[0]};
            d1  = {7'b0, i[1]};
            sel = i[2];
            #40;
            vecs++;
            if (z !== {7'b0, ztab[i]})
                begin errs++; $display("FAIL comb_sweep[%0d] got %h want %h", i, z, {7'b0, ztab[i]}); end
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_latency();
        d0 = 8'hA5; d1 = 8'h3C; sel = 1'b0;
        tick();
        tick();
        vecs++;
        if (z_q !== 8'hA5) begin errs++; $display("FAIL lat_pre_zq got %h want a5", z_q); end
        sel = 1'b1;
        #1;
        vecs++;
        if (z !== 8'h3C) begin errs++; $display("FAIL lat_z got %h want 3c", z); end
        vecs++;
        if (z_q !== 8'hA5) begin errs++; $display("FAIL lat_zq_hold got %h want a5", z_q); end
        tick();
        vecs++;
        if (z_q !== 8'h3C) begin errs++; $display("FAIL lat_zq got %h want 3c", z_q); end
        vecs++;
        if (sel_chg !== 1'b1) begin errs++; $display("FAIL lat_chg got %b want 1", sel_chg); end
        tick();
        vecs++;
        if (sel_chg !== 1'b0) begin errs++; $display("FAIL lat_chg_end got %b want 0", sel_chg); end
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 4; i++) begin
            sel = ~sel;
            tick();
            vecs++;
            if (sel_chg !== 1'b1) begin errs++; $display("FAIL toggle_chg[%0d] got %b want 1", i, sel_chg); end
        end
        tick();
        vecs++;
        if (sel_chg !== 1'b0) begin errs++; $display("FAIL toggle_hold got %b want 0", sel_chg); end
    endtask

`ifdef MUX2_SELCNT_EN
    task automatic test_selcnt();
        int want [5];
        want = '{1, 2, 3, 3, 3};
        rst = 1'b1; sel = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            sel = ~sel;
            tick();
            vecs++;
            if (sel_cnt !== CW'(want[i]))
                begin errs++; $display("FAIL selcnt[%0d] got %0d want %0d", i, sel_cnt, want[i]); end
        end
        sel = ~sel;
        rst = 1'b1;
        tick();
        vecs++;
        if (sel_cnt !== 2'd0) begin errs++; $display("FAIL selcnt_rst_prio got %0d want 0", sel_cnt); end
        rst = 1'b0;
    endtask
`endif

    task automatic test_mid_reset();
        sel = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vecs++;
            if (sel_chg !== 1'b0) begin errs++; $display("FAIL midrst_chg[%0d] got %b want 0", i, sel_chg); end
        end
        rst = 1'b0;
        tick();
        vecs++;
        if (sel_chg !== 1'b1) begin errs++; $display("FAIL midrst_release_chg got %b want 1", sel_chg); end
        tick();
        vecs++;
        if (sel_chg !== 1'b0) begin errs++; $display("FAIL midrst_after_chg got %b want 0", sel_chg); end
    endtask

    task automatic test_random();
        logic [W-1:0] zexp;
        for (int i = 0; i < 300; i++) begin
            d0  = W'($urandom);
            d1  = W'($urandom);
            sel = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 15) == 0);
            #1;
            zexp = sel ? d1 : d0;
            vecs++;
            if (z !== zexp) begin errs++; $display("FAIL rand_z[%0d] got %h want %h", i, z, zexp); end
            tick();
            vecs++;
            if (z_q !== m_zq) begin errs++; $display("FAIL rand_zq[%0d] got %h want %h", i, z_q, m_zq); end
            vecs++;
            if (sel_chg !== m_chg) begin errs++; $display("FAIL rand_chg[%0d] got %b want %b", i, sel_chg, m_chg); end
`ifdef MUX2_SELCNT_EN
            vecs++;
            if (sel_cnt !== CW'(m_cnt))
                begin errs++; $display("FAIL rand_cnt[%0d] got %0d want %0d", i, sel_cnt, m_cnt); end
`endif
        end
        rst = 1'b0;
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        m_zq = '0; m_chg = 1'b0; m_cnt = 0; m_prev_sel = 1'b0;
        rst = 1'b1; d0 = '0; d1 = '0; sel = 1'b0;
        test_reset();
        test_comb_sweep();
        test_latency();
        test_toggle();
`ifdef MUX2_SELCNT_EN
        test_selcnt();
`endif
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
